// File: rtl/voq_fifo_bank.sv
// Bank of NUM_Q first-word-fall-through FIFOs with one shared write port and one read port per queue.
// A write that cannot be accepted (full queue or out-of-range destination) bumps a saturating drop counter.
module voq_fifo_bank #(
    parameter int DATA_W    = 33,
    parameter int DEPTH     = 128,
    parameter int NUM_Q     = 4,
    parameter int QSEL_W    = 2,
    parameter int AF_THRESH = 120,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [QSEL_W-1:0]         wr_dest,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ready,
    input  logic [NUM_Q-1:0]          rd_en,
    output logic [NUM_Q*DATA_W-1:0]   rd_data,
    output logic [NUM_Q-1:0]          rd_valid,
    output logic [NUM_Q-1:0]          full,
    output logic [NUM_Q-1:0]          almost_full,
    output logic [NUM_Q*CNT_W-1:0]    count,
    output logic [15:0]               drop_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic        dest_ok;
    logic        dest_full;
    logic        wr_drop;
    logic [15:0] drop_q, drop_d;

    // When the select field cannot encode an index past the last queue, every destination is valid.
    generate
        if (NUM_Q >= (1 << QSEL_W)) begin : g_dest_all
            assign dest_ok = 1'b1;
        end else begin : g_dest_rng
            assign dest_ok = (wr_dest < QSEL_W'(NUM_Q));
        end
    endgenerate

    always_comb begin
        dest_full = 1'b0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (wr_dest == QSEL_W'(i)) begin
                dest_full = full[i];
            end
        end
    end

    assign wr_ready = dest_ok & ~dest_full;
    assign wr_drop  = wr_valid & ~wr_ready;

    always_comb begin
        drop_d = drop_q;
        if (wr_drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_Q; gi++) begin : g_q
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wptr_q, wptr_d;
            logic [PTR_W-1:0]  rptr_q, rptr_d;
            logic [CNT_W-1:0]  cnt_q, cnt_d;
            logic              wr_acc;
            logic              rd_acc;

            assign wr_acc = wr_valid & wr_ready & (wr_dest == QSEL_W'(gi));
            assign rd_acc = rd_en[gi] & (cnt_q != '0);

            // Pointers wrap naturally; the separate count keeps full and empty distinct.
            always_comb begin
                wptr_d = wptr_q + PTR_W'(wr_acc);
                rptr_d = rptr_q + PTR_W'(rd_acc);
                cnt_d  = cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                    cnt_q  <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst && wr_acc) begin
                    mem[wptr_q] <= wr_data;
                end
            end

            assign rd_valid[gi]                    = (cnt_q != '0);
            assign full[gi]                        = (cnt_q == CNT_W'(DEPTH));
            assign almost_full[gi]                 = (cnt_q >= CNT_W'(AF_THRESH));
            assign count[gi*CNT_W +: CNT_W]        = cnt_q;
            assign rd_data[gi*DATA_W +: DATA_W]    = (cnt_q != '0) ? mem[rptr_q] : '0;
        end
    endgenerate
endmodule

// File: tb/tb_voq_fifo_bank.sv
// Self-checking bench for voq_fifo_bank: table-driven vectors plus hand-written fill/wrap/reset sequences,
// with per-queue scoreboards filled on accepted writes and drained on pops.
module tb_voq_fifo_bank;
    localparam int DW    = 33;
    localparam int DEPTH = 128;
    localparam int NQ    = 4;
    localparam int CW    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic [1:0]      wr_dest;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic [NQ-1:0]   rd_en;
    logic [NQ*DW-1:0] rd_data;
    logic [NQ-1:0]   rd_valid;
    logic [NQ-1:0]   full;
    logic [NQ-1:0]   almost_full;
    logic [NQ*CW-1:0] count;
    logic [15:0]     drop_count;

    voq_fifo_bank dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_dest     (wr_dest),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench-side reference state
    int           mcnt [NQ];
    logic [15:0]  mdrop;
    logic [DW-1:0] sb [NQ][$];

    typedef struct {
        logic          wv;
        logic [1:0]    dest;
        logic [DW-1:0] data;
        logic [3:0]    rd;
        int            q;
        logic          ev;
        int            ecnt;
        logic [DW-1:0] ehead;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_state();
        for (int q = 0; q < NQ; q++) begin
            check("count", 64'(count[q*CW +: CW]), 64'(mcnt[q]));
            check("rd_valid", 64'(rd_valid[q]), 64'(mcnt[q] != 0));
            check("full", 64'(full[q]), 64'(mcnt[q] == DEPTH));
            check("almost_full", 64'(almost_full[q]), 64'(mcnt[q] >= 120));
            if (mcnt[q] == 0) check("head_empty", 64'(rd_data[q*DW +: DW]), 64'd0);
            else              check("head", 64'(rd_data[q*DW +: DW]), 64'(sb[q][0]));
        end
        check("drop_count", 64'(drop_count), 64'(mdrop));
    endtask

    task automatic cycle(input logic wv, input logic [1:0] dest, input logic [DW-1:0] data,
                         input logic [3:0] rd);
        logic       acc;
        logic [3:0] racc;
        logic [DW-1:0] exp;
        wr_valid = wv; wr_dest = dest; wr_data = data; rd_en = rd;
        #1;
        check("wr_ready", 64'(wr_ready), 64'(mcnt[dest] != DEPTH));
        racc = '0;
        for (int q = 0; q < NQ; q++) begin
            if (rd[q] && mcnt[q] != 0) begin
                racc[q] = 1'b1;
                exp = sb[q].pop_front();
                check("pop_data", 64'(rd_data[q*DW +: DW]), 64'(exp));
                $display("pop q%0d data %h expected %h", q, rd_data[q*DW +: DW], exp);
            end
        end
        acc = wv && (mcnt[dest] != DEPTH);
        if (wv && !acc && mdrop != 16'hFFFF) mdrop++;
        @(posedge clk);
        #1;
        for (int q = 0; q < NQ; q++) if (racc[q]) mcnt[q]--;
        if (acc) begin
            mcnt[dest]++;
            sb[dest].push_back(data);
        end
        wr_valid = 1'b0; rd_en = '0;
        check_state();
    endtask

    task automatic do_reset(input logic wv, input logic [1:0] dest, input logic [DW-1:0] data,
                            input logic [3:0] rd);
        rst = 1'b1;
        wr_valid = wv; wr_dest = dest; wr_data = data; rd_en = rd;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0; rd_en = '0;
        for (int q = 0; q < NQ; q++) begin
            mcnt[q] = 0;
            sb[q].delete();
        end
        mdrop = '0;
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_rd_data", 64'(|rd_data), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check_state();
    endtask

    function automatic void add(input logic wv, input logic [1:0] dest, input logic [DW-1:0] data,
                                input logic [3:0] rd, input int q, input logic ev, input int ecnt,
                                input logic [DW-1:0] ehead);
        vec_t v;
        v.wv = wv; v.dest = dest; v.data = data; v.rd = rd;
        v.q = q; v.ev = ev; v.ecnt = ecnt; v.ehead = ehead;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_dest = '0; wr_data = '0; rd_en = '0;
        mdrop = '0;
        for (int q = 0; q < NQ; q++) mcnt[q] = 0;

        // Queue 2 FIFO order, empty-read ignore; queue 1 simultaneous r/w; queue 3 read+write on empty
        add(1, 2, 33'h1_0000_00AA, 4'b0000, 2, 1, 1, 33'h1_0000_00AA);
        add(1, 2, 33'h0_0000_00BB, 4'b0000, 2, 1, 2, 33'h1_0000_00AA);
        add(1, 2, 33'h0_0000_00CC, 4'b0000, 2, 1, 3, 33'h1_0000_00AA);
        add(0, 0, 33'h0,           4'b0100, 2, 1, 2, 33'h0_0000_00BB);
        add(0, 0, 33'h0,           4'b0100, 2, 1, 1, 33'h0_0000_00CC);
        add(0, 0, 33'h0,           4'b0100, 2, 0, 0, 33'h0);
        add(0, 0, 33'h0,           4'b0100, 2, 0, 0, 33'h0);
        for (int i = 0; i < 5; i++) add(1, 1, 33'(32'h10 + i), 4'b0000, 1, 1, i + 1, 33'h10);
        add(1, 1, 33'h99,          4'b0010, 1, 1, 5, 33'h11);
        add(1, 3, 33'h33,          4'b1000, 3, 1, 1, 33'h33);
        add(0, 0, 33'h0,           4'b1000, 3, 0, 0, 33'h0);

        @(posedge clk);
        #1;
        do_reset(1'b0, 2'd0, '0, 4'b0000);

        foreach (vecs[i]) begin
            cycle(vecs[i].wv, vecs[i].dest, vecs[i].data, vecs[i].rd);
            check("vec_valid", 64'(rd_valid[vecs[i].q]), 64'(vecs[i].ev));
            check("vec_count", 64'(count[vecs[i].q*CW +: CW]), 64'(vecs[i].ecnt));
            check("vec_head", 64'(rd_data[vecs[i].q*DW +: DW]), 64'(vecs[i].ehead));
        end

        // Fill queue 0 to DEPTH and check the flow-control thresholds
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 2'd0, 33'(32'h1000 + i), 4'b0000);
            if (i == 118) check("af_below", 64'(almost_full[0]), 64'd0);
            if (i == 119) check("af_at_120", 64'(almost_full[0]), 64'd1);
            if (i == 126) check("not_full_127", 64'(full[0]), 64'd0);
        end
        check("full_128", 64'(full[0]), 64'd1);
        wr_dest = 2'd0;
        #1;
        check("wr_ready_full", 64'(wr_ready), 64'd0);
        cycle(1'b1, 2'd0, 33'h0_DEAD_BEEF, 4'b0000);
        check("drop_1", 64'(drop_count), 64'd1);
        check("cnt_stays_128", 64'(count[0 +: CW]), 64'd128);

        // Full queue: simultaneous write and read drops the write, read proceeds
        cycle(1'b1, 2'd0, 33'h0_BAD0_0000, 4'b0001);
        check("drop_2", 64'(drop_count), 64'd2);
        check("cnt_127", 64'(count[0 +: CW]), 64'd127);

        // Wrap-around on queue 1: drain, then 100 in/out, then values 0..99 across the wrap
        while (mcnt[1] != 0) cycle(1'b0, 2'd0, '0, 4'b0010);
        for (int i = 0; i < 100; i++) cycle(1'b1, 2'd1, 33'(32'h5000 + i), 4'b0000);
        for (int i = 0; i < 100; i++) cycle(1'b0, 2'd0, '0, 4'b0010);
        for (int i = 0; i < 100; i++) cycle(1'b1, 2'd1, 33'(i), 4'b0000);
        check("wrap_count", 64'(count[1*CW +: CW]), 64'd100);
        for (int i = 0; i < 100; i++) begin
            check("wrap_data", 64'(rd_data[1*DW +: DW]), 64'(i));
            cycle(1'b0, 2'd0, '0, 4'b0010);
        end
        check("wrap_empty", 64'(rd_valid[1]), 64'd0);

        // Mid-operation reset with a write and reads presented in the same cycle
        cycle(1'b1, 2'd2, 33'h77, 4'b0000);
        cycle(1'b1, 2'd3, 33'h88, 4'b0000);
        do_reset(1'b1, 2'd2, 33'h0_1234_5678, 4'b1111);
        cycle(1'b0, 2'd0, '0, 4'b0000);
        check("post_rst_no_write", 64'(rd_valid[2]), 64'd0);
        check("post_rst_count2", 64'(count[2*CW +: CW]), 64'd0);
        check("post_rst_data", 64'(|rd_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
